// File: rtl/fft_pkg.sv
// Shared definitions for the FFT readout back-end: FSM encoding, magnitude
// width and the abs() saturation constant.
package fft_pkg;

  localparam int MAG_STAGES = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_WAIT,
    CAPTURE,
    DRAIN,
    REPORT
  } state_t;

  function automatic int mag_width(input int w);
    return w + 1;
  endfunction

  // Largest positive value of a signed w-bit number: 2^(w-1)-1
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/spec_mag_approx.sv
// Three-stage magnitude estimate: |re|,|im| -> max/min -> max + min/2.
// Each stage loads only when its input is valid so the output holds between pulses.
module spec_mag_approx
  import fft_pkg::*;
#(
  parameter int width = 16,
  parameter int TAG_W = 9
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          in_valid,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic signed [width-1:0]       in_re,
  input  logic signed [width-1:0]       in_im,
  output logic                          out_valid,
  output logic [TAG_W-1:0]              out_tag,
  output logic [mag_width(width)-1:0]   out_mag
);

  localparam int MW = mag_width(width);
  localparam logic [width-1:0] SAT = width'(sat_max(width));
  localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  // The most negative input has no positive counterpart; clamp it.
  function automatic logic [width-1:0] abs_sat(input logic signed [width-1:0] x);
    logic [width-1:0] r;
    if (x == MOST_NEG) r = SAT;
    else if (x[width-1]) r = -x;
    else r = x;
    return r;
  endfunction

  logic [MAG_STAGES-1:0]            vld_pipe;
  logic [MAG_STAGES-1:0][TAG_W-1:0] tag_pipe;
  logic [width-1:0]                 a1, b1, hi2, lo2;
  logic [MW-1:0]                    mag3;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
      a1       <= '0;
      b1       <= '0;
      hi2      <= '0;
      lo2      <= '0;
      mag3     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[MAG_STAGES-2:0], in_valid};
      if (in_valid) begin
        a1          <= abs_sat(in_re);
        b1          <= abs_sat(in_im);
        tag_pipe[0] <= in_tag;
      end
      if (vld_pipe[0]) begin
        hi2         <= (a1 > b1) ? a1 : b1;
        lo2         <= (a1 > b1) ? b1 : a1;
        tag_pipe[1] <= tag_pipe[0];
      end
      if (vld_pipe[1]) begin
        mag3        <= MW'(hi2) + MW'(lo2 >> 1);
        tag_pipe[2] <= tag_pipe[1];
      end
    end
  end

  assign out_valid = vld_pipe[MAG_STAGES-1];
  assign out_tag   = tag_pipe[MAG_STAGES-1];
  assign out_mag   = mag3;

endmodule

// File: rtl/spec_peak_detect.sv
// Per-bin magnitude stream and per-frame peak search behind the FFT
// bit-reverse readout. Capture timing is driven by in_idx changes.
module spec_peak_detect
  import fft_pkg::*;
#(
  parameter int width   = 16,
  parameter int N       = 9,
  parameter int SETTLE  = 2,
  parameter int MIN_BIN = 2
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        in_en,
  input  logic [N-1:0]                in_idx,
  input  logic signed [width-1:0]     in_re,
  input  logic signed [width-1:0]     in_im,
  output logic                        mag_valid,
  output logic [N-1:0]                mag_bin,
  output logic [mag_width(width)-1:0] mag,
  output logic                        peak_valid,
  output logic [N-1:0]                peak_bin,
  output logic [mag_width(width)-1:0] peak_mag,
  output logic                        peak_partial
);

  localparam int MW = mag_width(width);
  localparam logic [N:0] FULL    = {1'b1, {N{1'b0}}};
  localparam logic [N:0] FULL_M1 = {1'b0, {N{1'b1}}};
  localparam logic [N:0] MIN_B   = (N+1)'(MIN_BIN);
  localparam logic [3:0] SET_M1  = 4'(SETTLE - 1);
  localparam logic [1:0] DRN_M1  = 2'(MAG_STAGES - 1);
  // The index-change cycle counts as the first settle cycle, so the capture
  // cycle lands exactly SETTLE cycles after the change.
  localparam state_t SETTLE_ENTRY = (SETTLE == 1) ? CAPTURE : SETTLE_WAIT;

  state_t       state, nstate;
  logic [3:0]   settle_cnt;
  logic [1:0]   drain_cnt;
  logic [N:0]   bin_cnt;
  logic         cap_done, en_q;
  logic [N-1:0] prev_idx;
  logic [MW-1:0] pk_mag;
  logic [N-1:0] pk_bin;
  logic         rise, idx_chg, capture, last_cap, settle_start;

  assign rise     = in_en & ~en_q;
  assign idx_chg  = in_idx != prev_idx;
  assign capture  = (state == CAPTURE) && !cap_done && in_en;
  assign last_cap = capture && (bin_cnt == FULL_M1);

  always_comb begin
    nstate       = state;
    settle_start = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          nstate       = SETTLE_ENTRY;
          settle_start = 1'b1;
        end
      end
      SETTLE_WAIT: begin
        if (!in_en) nstate = DRAIN;
        else if (idx_chg) begin
          nstate       = SETTLE_ENTRY;
          settle_start = 1'b1;
        end else if (settle_cnt == SET_M1) nstate = CAPTURE;
      end
      CAPTURE: begin
        if (!in_en || last_cap) nstate = DRAIN;
        else if (idx_chg) begin
          nstate       = SETTLE_ENTRY;
          settle_start = 1'b1;
        end
      end
      DRAIN:   if (drain_cnt == DRN_M1) nstate = REPORT;
      REPORT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      drain_cnt  <= '0;
      bin_cnt    <= '0;
      cap_done   <= 1'b0;
      en_q       <= 1'b0;
      prev_idx   <= '0;
    end else begin
      state    <= nstate;
      en_q     <= in_en;
      prev_idx <= in_idx;

      if (settle_start) settle_cnt <= 4'd1;
      else if (state == SETTLE_WAIT) settle_cnt <= settle_cnt + 4'd1;

      // CAPTURE doubles as the wait-for-next-index state; only its first cycle samples.
      if (settle_start) cap_done <= 1'b0;
      else if (capture) cap_done <= 1'b1;
      else if (state != CAPTURE) cap_done <= 1'b0;

      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else drain_cnt <= '0;

      if (state == IDLE && rise) bin_cnt <= '0;
      else if (capture) bin_cnt <= bin_cnt + 1'b1;
    end
  end

  spec_mag_approx #(
    .width (width),
    .TAG_W (N)
  ) u_mag (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (capture),
    .in_tag    (bin_cnt[N-1:0]),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (mag_valid),
    .out_tag   (mag_bin),
    .out_mag   (mag)
  );

  // Strict compare keeps the lowest bin on ties.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pk_mag <= '0;
      pk_bin <= '0;
    end else if (state == IDLE && rise) begin
      pk_mag <= '0;
      pk_bin <= '0;
    end else if (mag_valid && ({1'b0, mag_bin} >= MIN_B) && (mag > pk_mag)) begin
      pk_mag <= mag;
      pk_bin <= mag_bin;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      peak_valid   <= 1'b0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      peak_partial <= 1'b0;
    end else begin
      peak_valid <= (state == REPORT);
      if (state == REPORT) begin
        peak_bin     <= pk_bin;
        peak_mag     <= pk_mag;
        peak_partial <= (bin_cnt != FULL);
      end
    end
  end

endmodule

// File: tb/tb_spec_peak_detect.sv
// Bench for spec_peak_detect: table, directed corner sequences and random
// frames against a bin-list reference model.
module tb_spec_peak_detect;

  localparam int W = 16, NB = 4, ST = 2, MINB = 2, MW = W + 1, NBINS = 16;

  logic                 clk = 1'b0;
  logic                 areset, in_en;
  logic [NB-1:0]        in_idx;
  logic signed [W-1:0]  in_re, in_im;
  logic                 mag_valid, peak_valid, peak_partial;
  logic [NB-1:0]        mag_bin, peak_bin;
  logic [MW-1:0]        mag, peak_mag;

  spec_peak_detect #(.width(W), .N(NB), .SETTLE(ST), .MIN_BIN(MINB)) dut (
    .clk(clk), .areset(areset), .in_en(in_en), .in_idx(in_idx),
    .in_re(in_re), .in_im(in_im),
    .mag_valid(mag_valid), .mag_bin(mag_bin), .mag(mag),
    .peak_valid(peak_valid), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_partial(peak_partial)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int bin; int mag; int at; } mag_ev_t;
  typedef struct { int bin; int mag; int partial; } pk_ev_t;
  typedef struct { int re; int im; int exp; } vec_t;

  mag_ev_t got_q[$], exp_q[$];
  pk_ev_t  pk_q[$];
  int      cap_mag[$];
  int      ncap;
  int      nchk = 0, nerr = 0;
  int      lp_bin, lp_mag, lp_part;

  always @(negedge clk) begin
    if (!areset) begin
      if (mag_valid)  got_q.push_back('{int'(mag_bin), int'(mag), cyc});
      if (peak_valid) pk_q.push_back('{int'(peak_bin), int'(peak_mag), int'(peak_partial)});
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    return (a > b) ? a + b / 2 : b + a / 2;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bin presentation: idx change (or en rise) with data, held for `hold` cycles.
  // A bin is captured only if index and enable stay put through the settle window.
  task automatic present(input int re, input int im, input int hold, input bit first);
    if (first) begin
      in_en = 1'b1;
      ncap = 0;
      cap_mag.delete(); exp_q.delete(); got_q.delete(); pk_q.delete();
    end else begin
      in_idx = in_idx + 1'b1;
    end
    in_re = W'(re);
    in_im = W'(im);
    if (hold >= ST + 1 && ncap < NBINS) begin
      exp_q.push_back('{ncap, ref_mag(re, im), cyc + 3 + ST});
      cap_mag.push_back(ref_mag(re, im));
      ncap++;
    end
    tick(hold);
  endtask

  task automatic end_frame(input string tag);
    int pb, pm, n;
    pb = 0; pm = 0;
    for (int b = MINB; b < ncap; b++)
      if (cap_mag[b] > pm) begin pm = cap_mag[b]; pb = b; end
    in_en = 1'b0;
    for (int t = 0; t < 40 && pk_q.size() == 0; t++) tick(1);
    check({tag, " peak_count"}, pk_q.size(), 1);
    check({tag, " mag_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " mag_bin"}, got_q[i].bin, exp_q[i].bin);
      check({tag, " mag"}, got_q[i].mag, exp_q[i].mag);
      check({tag, " mag_cycle"}, got_q[i].at, exp_q[i].at);
    end
    lp_bin = -1; lp_mag = -1; lp_part = -1;
    if (pk_q.size() > 0) begin
      lp_bin = pk_q[0].bin; lp_mag = pk_q[0].mag; lp_part = pk_q[0].partial;
      check({tag, " peak_bin"}, lp_bin, pb);
      check({tag, " peak_mag"}, lp_mag, pm);
      check({tag, " peak_partial"}, lp_part, (ncap != NBINS) ? 1 : 0);
    end
    tick(4);
  endtask

  function automatic longint outs();
    return longint'({mag_valid, mag_bin, mag, peak_valid, peak_bin, peak_mag, peak_partial});
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int nb, hold, re, im;

    areset = 1'b1; in_en = 1'b0; in_idx = '0; in_re = '0; in_im = '0;
    tick(3);
    check("reset_outputs", outs(), 0);
    areset = 1'b0;
    tick(2);

    // Magnitude table, one row per bin
    tbl[0] = '{1500, -750, 1875};
    tbl[1] = '{-32768, -32768, 49150};
    tbl[2] = '{0, 0, 0};
    tbl[3] = '{32767, -32768, 49150};
    tbl[4] = '{-1, 2, 2};
    tbl[5] = '{3, -7, 8};
    tbl[6] = '{-32768, 0, 32767};
    tbl[7] = '{-20000, 12345, 26172};
    for (int i = 0; i < 8; i++) present(tbl[i].re, tbl[i].im, 6, i == 0);
    end_frame("tbl");
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("tbl_const_mag", got_q[i].mag, tbl[i].exp);
    check("tbl_const_peak_bin", lp_bin, 3);
    check("tbl_const_peak_mag", lp_mag, 49150);

    // Full 16-bin frame, index stepped every 20 cycles
    for (int k = 0; k < NBINS; k++) present(100 * k, -50 * k, 20, k == 0);
    end_frame("full");
    check("full_const_peak_bin", lp_bin, 15);
    check("full_const_peak_mag", lp_mag, 1875);
    check("full_const_partial", lp_part, 0);

    // DC exclusion and ties
    for (int k = 0; k < 12; k++) begin
      if (k == 0) present(9000, 0, 6, 1'b1);
      else if (k == 5 || k == 9) present(400, 0, 6, 1'b0);
      else present(10 * k, -5 * k, 6, 1'b0);
    end
    end_frame("ties");
    check("ties_const_peak_bin", lp_bin, 5);
    check("ties_const_peak_mag", lp_mag, 400);
    check("ties_const_partial", lp_part, 1);

    // Index toggles again one cycle after a change: one capture only
    present(1000, 7, 6, 1'b1);
    present(1001, 7, 6, 1'b0);
    present(5000, 5000, 1, 1'b0);
    present(300, -200, 8, 1'b0);
    present(1003, 7, 6, 1'b0);
    present(1004, 7, 6, 1'b0);
    end_frame("toggle");
    check("toggle_const_count", got_q.size(), 5);
    if (got_q.size() > 2) check("toggle_const_mag2", got_q[2].mag, 400);
    check("toggle_const_peak_bin", lp_bin, 4);

    // in_en drops after bin 6: bin 6 still flushes, a half-settled bin 7 is dropped
    for (int k = 0; k < 7; k++) present(200 * k, 100 * k, (k == 6) ? 3 : 6, k == 0);
    present(30000, 30000, 1, 1'b0);
    end_frame("endrop");
    check("endrop_const_count", got_q.size(), 7);
    check("endrop_const_peak_bin", lp_bin, 6);
    check("endrop_const_peak_mag", lp_mag, 1500);
    check("endrop_const_partial", lp_part, 1);

    // Reset in mid-frame
    for (int k = 0; k < 3; k++) present(3000 + k, 10, 6, k == 0);
    #2 areset = 1'b1;
    #1 check("async_reset_outputs", outs(), 0);
    in_en = 1'b0;
    tick(2);
    areset = 1'b0;
    got_q.delete(); pk_q.delete();
    tick(20);
    check("reset_no_peak", pk_q.size(), 0);
    check("reset_no_mag", got_q.size(), 0);
    for (int k = 0; k < 4; k++) present(700 - k, 50, 5, k == 0);
    end_frame("post_reset");
    if (got_q.size() > 0) check("post_reset_first_bin", got_q[0].bin, 0);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      nb = $urandom_range(1, 20);
      for (int k = 0; k < nb; k++) begin
        hold = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(3, 8);
        re = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        im = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
        present(re, im, hold, k == 0);
      end
      end_frame("rnd");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/spec_peak_detect.md
Name: spec_peak_detect

Overview:
- Sits directly downstream of the bit-reverse readout stage behind the pipelined R2 FFT.
- Consumes that stage's slow, natural-order bin stream: enable, bin counter, and re/im read data.
- Computes an approximate magnitude per bin and forwards it as a one-cycle-valid stream for display/UART back-ends.
- Tracks the per-frame peak bin, excluding low bins (DC), and reports it once per frame.

Parameters:
width, 16, bit width of signed input re/im.
N, 9, log2 of FFT length; bin index width.
SETTLE, 2, clk cycles from an index change to data capture (covers RAM read latency plus margin); legal 1..15.
MIN_BIN, 2, bins below this value are streamed but never eligible as peak.

Ports:
clk  in  1  system clock (40 MHz).
areset  in  1  asynchronous reset, active-high.
in_en  in  1  readout-active flag from upstream; high for a whole frame readout.
in_idx  in  N  upstream bin counter; a change marks a new bin on the data bus.
in_re  in  width  signed real part, valid SETTLE cycles after an in_idx change.
in_im  in  width  signed imaginary part, same timing as in_re.
mag_valid  out  1  one-cycle pulse per captured bin.
mag_bin  out  N  frame-relative bin number of the current mag.
mag  out  width+1  unsigned magnitude estimate.
peak_valid  out  1  one-cycle pulse at end of frame.
peak_bin  out  N  bin of the largest eligible mag in the frame.
peak_mag  out  width+1  that magnitude.
peak_partial  out  1  1 when the frame ended before 2^N bins were captured; valid with peak_valid.

Behaviour:
- Reset: every output 0; FSM to IDLE; bin counter, peak registers, and previous-index register cleared. Reset asserted mid-frame aborts the frame: no peak_valid is emitted.
- FSM states: IDLE, SETTLE_WAIT, CAPTURE, DRAIN, REPORT.
- IDLE -> SETTLE_WAIT on in_en rising (first bin, no index change needed). Rising edge also clears bin counter, peak_mag = 0, peak_bin = 0.
- In IDLE, an in_idx change is ignored.
- In CAPTURE with in_en high, an in_idx change (versus the registered previous value) -> SETTLE_WAIT.
- SETTLE_WAIT counts SETTLE cycles, then -> CAPTURE. The capture cycle samples in_re/in_im into pipeline stage 1 tagged with the bin counter; bin counter then increments.
- An in_idx change during SETTLE_WAIT restarts the settle count. The pending bin is dropped (not captured twice); the counter does not increment for it.
- in_en falling in any active state -> DRAIN. A sample already in the pipeline completes; an uncaptured settle is discarded.
- Bin counter reaching 2^N captured bins -> DRAIN after the last capture; further index changes are ignored until in_en falls and rises again.
- DRAIN waits for the pipeline to empty (3 cycles), then -> REPORT.
- REPORT: peak_valid = 1 for one cycle, peak_partial = (captured count != 2^N); then -> IDLE.
- If in_en is still high in IDLE after a full frame, no new frame starts until a fresh rising edge.
- Magnitude pipeline, 3 registered stages; mag_valid exactly 3 cycles after the capture cycle.
  - Stage 1: absolute values, width bits unsigned; the most negative input saturates to 2^(width-1)-1.
  - Stage 2: hi = max, lo = min.
  - Stage 3: mag = hi + (lo >> 1), zero-extended to width+1 bits; no overflow possible.
- Peak update on each mag_valid with mag_bin >= MIN_BIN: replace when mag > peak_mag (strict; ties keep the lower bin).
- A frame where no eligible bin was captured reports peak_bin = 0, peak_mag = 0.
- Outputs registered; mag/mag_bin hold their last value between pulses.

Decomposition:
- Shared package fft_pkg: magnitude width function (width+1), FSM state encoding, saturation constant 2^(width-1)-1.
- One natural sub-module: spec_mag_approx (the 3-stage abs/max-min/sum pipeline, valid in/out). The FSM and peak tracker stay in the top.

Test Plan:
- Full frame, N=4 (16 bins), SETTLE=2; bin k fed as re=100*k, im=-50*k; in_idx stepped every 20 cycles -> 16 mag_valid pulses, each 5 cycles after its index change. Bin 15: mag = 1500+375 = 1875. peak_bin=15, peak_mag=1875, peak_partial=0.
- re=-32768, im=-32768 -> mag = 32767+16383 = 49150; no wrap.
- Ties and DC exclusion, MIN_BIN=2:
  - bin0 = 9000, bins 5 and 9 = 400 each, others lower -> peak_bin=5, peak_mag=400.
- in_idx toggles again 1 cycle after a change -> exactly one capture for that bin; bin counter advances by 1.
- in_en drops after bin 6 -> pending pipeline output still emitted; then peak_valid with peak_partial=1.
- areset pulsed mid-frame -> all outputs 0 asynchronously, no peak_valid. Next in_en rise starts a clean frame at mag_bin=0.
